// File: rtl/ybus_delta_rmw_if.sv
// Bus bundle for ybus_delta_rmw: change-record handshake, Y SRAM read and
// write ports, and status outputs. The slave modport is the update block's
// view. The master modport is the view of the record source plus the SRAM.
interface ybus_delta_rmw_if #(
   parameter int DATA_W = 24,
   parameter int IDX_W  = 16,
   parameter int ADDR_W = 11,
   parameter int ELEMS  = 4
);
   logic                        chg_valid;
   logic                        chg_ready;
   logic [IDX_W-1:0]            chg_row;
   logic [IDX_W-1:0]            chg_col;
   logic signed [DATA_W-1:0]    chg_real;
   logic signed [DATA_W-1:0]    chg_img;
   logic                        mem_rd_en;
   logic [ADDR_W-1:0]           mem_rd_addr;
   logic [ELEMS*2*DATA_W-1:0]   mem_rd_data;
   logic                        mem_wr_en;
   logic [ADDR_W-1:0]           mem_wr_addr;
   logic [ELEMS*2*DATA_W-1:0]   mem_wr_data;
   logic                        busy;
   logic                        upd_done;
   logic                        idx_err;
   logic                        sat_flag;

   modport slave (
      input  chg_valid, chg_row, chg_col, chg_real, chg_img, mem_rd_data,
      output chg_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
             mem_wr_data, busy, upd_done, idx_err, sat_flag
   );

   modport master (
      output chg_valid, chg_row, chg_col, chg_real, chg_img, mem_rd_data,
      input  chg_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr,
             mem_wr_data, busy, upd_done, idx_err, sat_flag
   );
endinterface

// File: rtl/ybus_delta_rmw.sv
// ybus_delta_rmw: applies one branch admittance change dy between buses i
// and j to a word-packed Y SRAM. Each record is applied as up to four serial
// read-modify-write updates: Yii+=dy, Yjj+=dy, Yij-=dy, Yji-=dy.
// Optional feature: define YBUS_RMW_SAT_EN to saturate the results and keep
// a sticky sat_flag. Without it the results wrap and sat_flag stays 0.
module ybus_delta_rmw #(
   parameter int DATA_W  = 24,
   parameter int IDX_W   = 16,
   parameter int ADDR_W  = 11,
   parameter int N_BUS   = 64,
   parameter int ELEMS   = 4,
   parameter int WPR     = 16,
   parameter int MEM_LAT = 1
) (
   input logic            clock,
   input logic            reset,
   ybus_delta_rmw_if.slave bus
);
   localparam int WORD_W = ELEMS * 2 * DATA_W;
   localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         row_q, row_d, col_q, col_d;
   logic signed [DATA_W-1:0] re_q, re_d, im_q, im_d;
   logic                     shunt_q, shunt_d;
   logic [1:0]               step_q, step_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [WORD_W-1:0]        wdata_q, wdata_d;
   logic                     idx_err_q, idx_err_d;
   logic                     sat_q, sat_d;

   logic [IDX_W-1:0]         r_sel, c_sel;
   logic [ADDR_W-1:0]        cur_addr;
   int                       lane_sel;
   logic                     neg;
   logic signed [DATA_W-1:0] old_re, old_im;
   logic signed [DATA_W:0]   sum_re, sum_im;
   logic [WORD_W-1:0]        new_word;
   logic                     bad_idx;
`ifdef YBUS_RMW_SAT_EN
   logic                     clip_any;
`endif

   // Reduce a DATA_W+1 bit sum to DATA_W bits: clip or wrap.
   function automatic logic [DATA_W-1:0] fit(input logic [DATA_W:0] s);
`ifdef YBUS_RMW_SAT_EN
      if (s[DATA_W] != s[DATA_W-1])
         fit = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         fit = DATA_W'(s);
`else
      fit = DATA_W'(s);
`endif
   endfunction

   // Target element of the current update, its word address and lane, and the modified word.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      r_sel = row_q;
      c_sel = row_q;
      unique case (step_q)
         2'd0: begin r_sel = row_q; c_sel = row_q; end
         2'd1: begin r_sel = col_q; c_sel = col_q; end
         2'd2: begin r_sel = row_q; c_sel = col_q; end
         default: begin r_sel = col_q; c_sel = row_q; end
      endcase
      neg      = step_q[1];
      cur_addr = ADDR_W'(32'(r_sel) * 32'(WPR) + 32'(c_sel) / 32'(ELEMS));
      lane_sel = int'(32'(c_sel) % 32'(ELEMS));
      old_re   = bus.mem_rd_data[lane_sel*2*DATA_W + DATA_W +: DATA_W];
      old_im   = bus.mem_rd_data[lane_sel*2*DATA_W +: DATA_W];
      // Sign-extend both sides first, so negating -2^(DATA_W-1) cannot overflow.
      if (neg) begin
         sum_re = {old_re[DATA_W-1], old_re} - {re_q[DATA_W-1], re_q};
         sum_im = {old_im[DATA_W-1], old_im} - {im_q[DATA_W-1], im_q};
      end else begin
         sum_re = {old_re[DATA_W-1], old_re} + {re_q[DATA_W-1], re_q};
         sum_im = {old_im[DATA_W-1], old_im} + {im_q[DATA_W-1], im_q};
      end
`ifdef YBUS_RMW_SAT_EN
      clip_any = (sum_re[DATA_W] != sum_re[DATA_W-1]) || (sum_im[DATA_W] != sum_im[DATA_W-1]);
`endif
      new_word = bus.mem_rd_data;
      new_word[lane_sel*2*DATA_W +: 2*DATA_W] = {fit(sum_re), fit(sum_im)};
      bad_idx  = (32'(bus.chg_row) >= 32'(N_BUS)) || (32'(bus.chg_col) >= 32'(N_BUS));
   end

   // Next state and next register values of the RMW sequencer.
   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      re_d      = re_q;
      im_d      = im_q;
      shunt_d   = shunt_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      wdata_d   = wdata_q;
      idx_err_d = 1'b0;
      sat_d     = sat_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.chg_valid) begin
               if (bad_idx) begin
                  idx_err_d = 1'b1;
               end else begin
                  row_d   = bus.chg_row;
                  col_d   = bus.chg_col;
                  re_d    = bus.chg_real;
                  im_d    = bus.chg_img;
                  shunt_d = (bus.chg_row == bus.chg_col);
                  step_d  = 2'd0;
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
               wdata_d = new_word;
`ifdef YBUS_RMW_SAT_EN
               sat_d   = sat_q | clip_any;
`endif
               state_d = S_WR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR: begin
            if (shunt_q || step_q == 2'd3) begin
               state_d = S_DONE;
            end else begin
               step_d  = step_q + 2'd1;
               state_d = S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifndef YBUS_RMW_SAT_EN
      sat_d = 1'b0;
`endif
   end

   // State register with synchronous reset. A reset mid-record abandons the record.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (reset) begin
         state_q   <= S_IDLE;
         row_q     <= '0;
         col_q     <= '0;
         re_q      <= '0;
         im_q      <= '0;
         shunt_q   <= 1'b0;
         step_q    <= '0;
         cnt_q     <= '0;
         wdata_q   <= '0;
         idx_err_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         re_q      <= re_d;
         im_q      <= im_d;
         shunt_q   <= shunt_d;
         step_q    <= step_d;
         cnt_q     <= cnt_d;
         wdata_q   <= wdata_d;
         idx_err_q <= idx_err_d;
         sat_q     <= sat_d;
      end
   end

   assign bus.chg_ready   = (state_q == S_IDLE);
   assign bus.mem_rd_en   = (state_q == S_RD);
   assign bus.mem_rd_addr = cur_addr;
   assign bus.mem_wr_en   = (state_q == S_WR);
   assign bus.mem_wr_addr = cur_addr;
   assign bus.mem_wr_data = wdata_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.upd_done    = (state_q == S_DONE);
   assign bus.idx_err     = idx_err_q;
   assign bus.sat_flag    = sat_q;
endmodule

// File: tb/tb_ybus_delta_rmw.sv
// Directed testbench for ybus_delta_rmw (N_BUS=8, ELEMS=4, WPR=2, MEM_LAT=1).
// A synchronous SRAM model with one cycle of read latency logs every write.
module tb_ybus_delta_rmw;
   localparam int DW = 24;
   localparam int WW = 4 * 2 * DW;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   ybus_delta_rmw_if #(.DATA_W(DW), .IDX_W(16), .ADDR_W(11), .ELEMS(4)) bus ();

   ybus_delta_rmw #(
      .DATA_W(DW), .IDX_W(16), .ADDR_W(11), .N_BUS(8),
      .ELEMS(4), .WPR(2), .MEM_LAT(1)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [WW-1:0] mem [0:15];
   logic [WW-1:0] rd_data_q;
   logic [WW-1:0] log_data [0:15];
   logic [10:0]   log_addr [0:15];
   int            wr_cnt, rd_cnt, err_cnt;
   logic          tb_clr = 1'b1;
   logic          tb_pre_en = 1'b0;
   logic [3:0]    tb_pre_addr = '0;
   logic [WW-1:0] tb_pre_data = '0;

   assign bus.mem_rd_data = rd_data_q;

   // SRAM model and write/read/error logging.
   always @(posedge clock) begin
      if (tb_clr) begin
         for (int k = 0; k < 16; k++) mem[k] <= '0;
         rd_data_q <= '0;
         wr_cnt    <= 0;
         rd_cnt    <= 0;
         err_cnt   <= 0;
      end else begin
         if (tb_pre_en) mem[tb_pre_addr] <= tb_pre_data;
         if (bus.mem_rd_en) begin
            rd_data_q <= mem[bus.mem_rd_addr[3:0]];
            rd_cnt    <= rd_cnt + 1;
         end
         if (bus.mem_wr_en) begin
            mem[bus.mem_wr_addr[3:0]] <= bus.mem_wr_data;
            if (wr_cnt < 16) begin
               log_addr[wr_cnt] <= bus.mem_wr_addr;
               log_data[wr_cnt] <= bus.mem_wr_data;
            end
            wr_cnt <= wr_cnt + 1;
         end
         if (bus.idx_err) err_cnt <= err_cnt + 1;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] pack(input int lane, input int re, input int im);
      logic [WW-1:0] w;
      w = '0;
      w[lane*2*DW +: 2*DW] = {24'(re), 24'(im)};
      return w;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_mem();
      tb_clr = 1'b1;
      tick();
      tb_clr = 1'b0;
   endtask

   task automatic preload(input int addr, input logic [WW-1:0] word);
      tb_pre_en   = 1'b1;
      tb_pre_addr = 4'(addr);
      tb_pre_data = word;
      tick();
      tb_pre_en   = 1'b0;
   endtask

   task automatic put(input int row, input int col, input int re, input int im);
      bus.chg_row  = 16'(row);
      bus.chg_col  = 16'(col);
      bus.chg_real = 24'(re);
      bus.chg_img  = 24'(im);
   endtask

   // Present a record, wait for its accept edge; on return the bench sits in cycle 1.
   task automatic accept(input int row, input int col, input int re, input int im);
      int n;
      put(row, col, re, im);
      bus.chg_valid = 1'b1;
      n = 0;
      while (!bus.chg_ready && n < 50) begin tick(); n++; end
      tick();
   endtask

   // Counts cycles from accept (cycle 1 on entry) to upd_done; 60 means it never came.
   task automatic wait_done(output int lat);
      lat = 1;
      while (!bus.upd_done && lat < 60) begin tick(); lat++; end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_ready"},   WW'(bus.chg_ready),   WW'(1));
      check({pfx, "_rd_en"},   WW'(bus.mem_rd_en),   WW'(0));
      check({pfx, "_wr_en"},   WW'(bus.mem_wr_en),   WW'(0));
      check({pfx, "_busy"},    WW'(bus.busy),        WW'(0));
      check({pfx, "_done"},    WW'(bus.upd_done),    WW'(0));
      check({pfx, "_idx_err"}, WW'(bus.idx_err),     WW'(0));
      check({pfx, "_sat"},     WW'(bus.sat_flag),    WW'(0));
      check({pfx, "_rd_addr"}, WW'(bus.mem_rd_addr), WW'(0));
      check({pfx, "_wr_addr"}, WW'(bus.mem_wr_addr), WW'(0));
      check({pfx, "_wr_data"}, bus.mem_wr_data,      WW'(0));
   endtask

   initial begin
      int lat, viol, rd0, wr0;
      logic [23:0] exp_re;
      logic        exp_sat;

      bus.chg_valid = 1'b0;
      put(0, 0, 0, 0);
      repeat (3) tick();
      check_reset_outputs("rst");
      reset  = 1'b0;
      tb_clr = 1'b0;
      tick();

      // Record (1,2): four writes in fixed order, same-word updates compose.
      accept(1, 2, 5, -3);
      bus.chg_valid = 1'b0;
      wait_done(lat);
      check("lat_ij", WW'(lat), WW'(13));
      check("wr_cnt_ij", WW'(wr_cnt), WW'(4));
      check("w0_addr", WW'(log_addr[0]), WW'(2));
      check("w0_data", log_data[0], pack(1, 5, -3));
      check("w1_addr", WW'(log_addr[1]), WW'(4));
      check("w1_data", log_data[1], pack(2, 5, -3));
      check("w2_addr", WW'(log_addr[2]), WW'(2));
      check("w2_data", log_data[2], pack(1, 5, -3) | pack(2, -5, 3));
      check("w3_addr", WW'(log_addr[3]), WW'(4));
      check("w3_data", log_data[3], pack(2, 5, -3) | pack(1, -5, 3));
      tick();
      check("idle_busy", WW'(bus.busy), WW'(0));
      check("idle_ready", WW'(bus.chg_ready), WW'(1));

      // Shunt record (3,3): one write.
      accept(3, 3, 7, 0);
      bus.chg_valid = 1'b0;
      wait_done(lat);
      check("lat_shunt", WW'(lat), WW'(4));
      check("wr_cnt_shunt", WW'(wr_cnt), WW'(5));
      check("shunt_addr", WW'(log_addr[4]), WW'(6));
      check("shunt_data", log_data[4], pack(3, 7, 0));
      tick();

      // Out-of-range record: idx_err pulse, no memory traffic.
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      put(8, 1, 1, 1);
      bus.chg_valid = 1'b1;
      tick();
      bus.chg_valid = 1'b0;
      check("idx_err_pulse", WW'(bus.idx_err), WW'(1));
      check("idx_ready0", WW'(bus.chg_ready), WW'(1));
      tick();
      check("idx_err_drop", WW'(bus.idx_err), WW'(0));
      check("idx_ready1", WW'(bus.chg_ready), WW'(1));
      repeat (3) tick();
      check("idx_err_cnt", WW'(err_cnt), WW'(1));
      check("idx_no_rd", WW'(rd_cnt), WW'(rd0));
      check("idx_no_wr", WW'(wr_cnt), WW'(wr0));
      check("idx_busy", WW'(bus.busy), WW'(0));

      // Overflow of Y00.re: wrap or saturate depending on the build.
      clear_mem();
      preload(0, pack(0, 8388606, 0));
`ifdef YBUS_RMW_SAT_EN
      exp_re  = 24'h7FFFFF;
      exp_sat = 1'b1;
`else
      exp_re  = 24'h800003;
      exp_sat = 1'b0;
`endif
      accept(0, 1, 5, 0);
      bus.chg_valid = 1'b0;
      wait_done(lat);
      check("lat_sat", WW'(lat), WW'(13));
      tick();
      check("y00_re", WW'(mem[0][47:24]), WW'(exp_re));
      check("y01_re", WW'(mem[0][95:72]), WW'(24'hFFFFFB));
      check("word2", mem[2], pack(1, 5, 0) | pack(0, -5, 0));
      check("sat_flag", WW'(bus.sat_flag), WW'(exp_sat));

      // Back-to-back: second record waits for the cycle after upd_done.
      clear_mem();
      accept(1, 2, 5, -3);
      put(3, 3, 7, 0);
      viol = 0;
      lat  = 1;
      while (!bus.upd_done && lat < 60) begin
         if (bus.chg_ready || !bus.busy) viol++;
         tick();
         lat++;
      end
      check("b2b_lat", WW'(lat), WW'(13));
      check("b2b_viol", WW'(viol), WW'(0));
      check("b2b_ready_done", WW'(bus.chg_ready), WW'(0));
      tick();
      check("b2b_ready_idle", WW'(bus.chg_ready), WW'(1));
      check("b2b_wr_cnt_a", WW'(wr_cnt), WW'(4));
      tick();
      bus.chg_valid = 1'b0;
      check("b2b_busy_b", WW'(bus.busy), WW'(1));
      check("b2b_ready_b", WW'(bus.chg_ready), WW'(0));
      wait_done(lat);
      check("b2b_lat_b", WW'(lat), WW'(4));
      repeat (3) tick();
      check("b2b_wr_cnt", WW'(wr_cnt), WW'(5));
      check("b2b_addr_b", WW'(log_addr[4]), WW'(6));

      // Reset during the WAIT of the third update.
      clear_mem();
      accept(1, 2, 5, -3);
      bus.chg_valid = 1'b0;
      repeat (6) tick();
      check("mid_rd3_en", WW'(bus.mem_rd_en), WW'(1));
      check("mid_rd3_addr", WW'(bus.mem_rd_addr), WW'(2));
      tick();
      check("mid_wait_busy", WW'(bus.busy), WW'(1));
      check("mid_wait_wr", WW'(bus.mem_wr_en), WW'(0));
      reset = 1'b1;
      tick();
      check_reset_outputs("mid");
      reset = 1'b0;
      repeat (5) tick();
      check("mid_wr_cnt", WW'(wr_cnt), WW'(2));
      check("mid_word2", mem[2], pack(1, 5, -3));
      check("mid_word4", mem[4], pack(2, 5, -3));
      check("mid_busy_after", WW'(bus.busy), WW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ybus_delta_rmw.md
Name: ybus_delta_rmw

Overview:
- Parametrised successor to the change-in-Y update path.
- Accepts one branch-change record per handshake: bus i, bus j, and complex admittance delta dy.
- Applies the full symmetric Y-bus update to a word-organised Y SRAM using read-modify-write: Yii+=dy, Yjj+=dy, Yij-=dy, Yji-=dy.
- Sits between the change-record source and the Y SRAM port. Generalises element width, bus count, packing density and memory latency, and adds range checking, saturation and back-pressure.

Parameters:
- DATA_W, 24: signed width of each real and each imaginary component.
- IDX_W, 16: width of bus index inputs.
- ADDR_W, 11: Y SRAM address width.
- N_BUS, 64: number of buses. Valid indices are 0..N_BUS-1.
- ELEMS, 4: complex elements per SRAM word. Must be a power of two.
- WPR, 16: SRAM words per Y row. Must be >= ceil(N_BUS/ELEMS).
- MEM_LAT, 1: SRAM read latency in cycles, >= 1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- chg_valid  in  1  change record present.
- chg_ready  out  1  block can accept a record.
- chg_row  in  IDX_W  bus i.
- chg_col  in  IDX_W  bus j.
- chg_real  in  DATA_W  signed Re(dy).
- chg_img  in  DATA_W  signed Im(dy).
- mem_rd_en  out  1  SRAM read strobe.
- mem_rd_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  ELEMS*2*DATA_W  SRAM read data.
- mem_wr_en  out  1  SRAM write strobe.
- mem_wr_addr  out  ADDR_W  SRAM write address.
- mem_wr_data  out  ELEMS*2*DATA_W  SRAM write data.
- busy  out  1  record in progress.
- upd_done  out  1  one-cycle pulse when a record completes.
- idx_err  out  1  one-cycle pulse when a record is rejected.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: chg_ready=1; mem_rd_en, mem_wr_en, busy, upd_done, idx_err, sat_flag all 0; addresses and write data 0; FSM in IDLE.
- Handshake:
  - A record is accepted on the cycle where chg_valid && chg_ready, and latched.
  - chg_ready is 1 only in IDLE.
  - Inputs are don't-care when chg_ready=0.
- Range check at accept:
  - If chg_row>=N_BUS or chg_col>=N_BUS, pulse idx_err the next cycle.
  - No memory access occurs; the FSM stays in IDLE.
- Update list:
  - i!=j: four updates in fixed order (i,i,+), (j,j,+), (i,j,-), (j,i,-).
  - i==j (shunt change): a single update (i,i,+).
- Address and lane for element (r,c): addr = r*WPR + c/ELEMS; lane = c%ELEMS.
- Packing:
  - Lane k occupies bits [k*2*DATA_W +: 2*DATA_W].
  - Real part is in the upper DATA_W bits, imaginary part in the lower DATA_W bits.
- FSM states: IDLE -> RD -> WAIT -> WR -> (next update ? RD : DONE) -> IDLE.
  - RD, 1 cycle: mem_rd_en=1, mem_rd_addr=addr.
  - WAIT, MEM_LAT cycles: mem_rd_data is sampled exactly MEM_LAT cycles after the RD cycle, and the modified word is registered.
  - WR, 1 cycle: mem_wr_en=1, mem_wr_addr=addr, mem_wr_data=the read word with only the target lane replaced. Other lanes pass through bit-exact.
  - DONE, 1 cycle: upd_done=1, busy=0 next cycle.
- busy=1 from RD of the first update through DONE.
- Latency, accept to upd_done: 4*(MEM_LAT+2)+1 cycles for i!=j; (MEM_LAT+2)+1 cycles for i==j.
- Read-after-write: the RMWs are strictly serial. Each read is issued after the prior write cycle, so same-word updates (e.g. Yij and Yii in one word) compose correctly.
- Arithmetic: per component, result = old ± delta in DATA_W+1 bits, then reduced to DATA_W bits as set by the optional feature.
- Negation of a delta equal to -2^(DATA_W-1) is computed in DATA_W+1 bits, so there is no intermediate overflow.
- Reset mid-record: the FSM returns to IDLE at that edge and both strobes drop. The partial update is abandoned, with no rollback.

Optional Feature:
- Macro YBUS_RMW_SAT_EN.
- Defined: results are clipped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clip sets sat_flag, which stays set until reset.
- Undefined: two's-complement wrap to DATA_W bits, and sat_flag is tied to 0.

Test Plan (N_BUS=8, ELEMS=4, WPR=2, MEM_LAT=1, DATA_W=24, memory preloaded with zeros):
- Record (i=1, j=2, re=5, im=-3):
  - Writes in order: addr2 lane1 = (5,-3), addr4 lane2 = (5,-3), addr2 lane2 = (-5,3), addr4 lane1 = (-5,3).
  - The second write to addr2 preserves lane1 = (5,-3).
  - upd_done occurs 13 cycles after accept.
- Shunt record (3,3, re=7, im=0): exactly one write, addr6 lane3 = (7,0); upd_done 4 cycles after accept.
- Record (8,1,...): idx_err pulses once; no mem_rd_en or mem_wr_en; chg_ready stays 1.
- Preload addr0 lane0 = (2^23-2, 0), then record (0,1, re=5, im=0):
  - With YBUS_RMW_SAT_EN: Y00.re = 8388607 and sat_flag=1.
  - Without it: Y00.re = -8388605 and sat_flag=0.
- Back-to-back valid records: the second is accepted only on the cycle after upd_done. chg_ready=0 throughout busy.
- Reset asserted during the WAIT of the third update: next cycle all outputs are at reset values. Only the first two writes are visible in memory.
